// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
//   mode_e        : operation select (ADD, SUB, CMP, RSVD; RSVD behaves as ADD)
//   state_e       : sequencer states (IDLE, CALC, DONE)
//   clog2_chunks  : width of the chunk index counter, never less than 1 bit
package addsub_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    CMP  = 2'd2,
    RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit counter so that the
  // index register has a legal width.
  function automatic int clog2_chunks(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Request/response bundle of the serial add/subtract unit.
//   Request : in_valid, in_ready, a, b, ci, mode
//   Response: out_valid, out_ready, s, co, ofl, z, n
// The master modport is the requester/consumer side, slave is the unit.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ci;
  addsub_pkg::mode_e    mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     s;
  logic                 co;
  logic                 ofl;
  logic                 z;
  logic                 n;

  modport master (
    output in_valid, a, b, ci, mode, out_ready,
    input  in_ready, out_valid, s, co, ofl, z, n
  );

  modport slave (
    input  in_valid, a, b, ci, mode, out_ready,
    output in_ready, out_valid, s, co, ofl, z, n
  );
endinterface

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the carry chain (purely combinational).
//   a, b_eff : operand slices (b already inverted for SUB/CMP)
//   ci       : carry into the slice
//   sum      : slice result
//   co       : carry out of the slice MSB
//   c_msb    : carry into the slice MSB, used for signed overflow
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_eff,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, ci};
    sum   = full[CHUNK-1:0];
    co    = full[CHUNK];
    // The MSB sum bit is a ^ b ^ carry_in, so the incoming carry falls out
    // of the sum without a second adder.
    c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];
  end
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit ADD/SUB/CMP, CHUNK bits per clock, carry held in a
// register between slices. Produces carry, signed overflow, zero and negative
// flags. Handshakes: valid/ready on request and response sides.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : addsub_seq_if slave modport (request + response signals)
// The interface instance must be built with the same WIDTH as this module.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  addsub_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = clog2_chunks(NCHUNK);
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  state_e            state;
  logic [KW-1:0]     k;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  s_reg;
  logic              carry;
  logic              is_cmp;
  logic              out_valid_r;
  logic              co_r;
  logic              ofl_r;
  logic              z_r;
  logic              n_r;

  logic              ready;
  logic              accept;
  logic              last;
  int                base;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  sum;
  logic              c_next;
  logic              c_msb;
  logic [WIDTH-1:0]  s_next;

  // Ready is forced low while reset is asserted so nothing is accepted on
  // the reset edge.
  always_comb begin
    ready  = reset_n && ((state == IDLE) || (state == DONE && bus.out_ready));
    accept = bus.in_valid && ready;
    last   = (k == LAST_K);
  end

  always_comb begin
    base    = int'(k) * CHUNK;
    a_chunk = a_reg[base +: CHUNK];
    b_chunk = b_reg[base +: CHUNK];
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b_eff (b_chunk),
    .ci    (carry),
    .sum   (sum),
    .co    (c_next),
    .c_msb (c_msb)
  );

  // Result word with the current slice merged in; on the last slice this is
  // the final result that z/n are derived from.
  always_comb begin
    s_next               = s_reg;
    s_next[base +: CHUNK] = sum;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      k           <= '0;
      out_valid_r <= 1'b0;
      s_reg       <= '0;
      co_r        <= 1'b0;
      ofl_r       <= 1'b0;
      z_r         <= 1'b0;
      n_r         <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        // ---- slice stage: one CHUNK of the chain per clock ----
        CALC: begin
          s_reg <= s_next;
          carry <= c_next;
          if (last) begin
            co_r        <= c_next;
            ofl_r       <= (c_msb ^ c_next) & ~is_cmp;
            z_r         <= (s_next == '0);
            n_r         <= s_next[WIDTH-1];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        // ---- result stage: hold until the consumer takes it ----
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept overrides the IDLE/DONE next-state so a DONE handshake with a
      // waiting request goes straight back into CALC.
      if (accept) begin
        a_reg  <= bus.a;
        b_reg  <= (bus.mode == SUB || bus.mode == CMP) ? ~bus.b : bus.b;
        carry  <= (bus.mode == CMP) ? 1'b1 : bus.ci;
        is_cmp <= (bus.mode == CMP);
        k      <= '0;
        state  <= CALC;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_reg;
  assign bus.co        = co_r;
  assign bus.ofl       = ofl_r;
  assign bus.z         = z_r;
  assign bus.n         = n_r;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: a 16-bit/8-chunk instance and an 8-bit/8-chunk
// instance, driven through addsub_seq_if, with a queue scoreboard per unit.
module tb_addsub_seq;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(16)) bus16 ();
  addsub_seq_if #(.WIDTH(8))  bus8 ();

  addsub_seq #(.WIDTH(16), .CHUNK(8)) dut16 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus16)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] res;   // {ofl, co, z, n, s[15:0]}
    int          acc;   // number of the posedge that accepted the op
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain w-bit modular arithmetic, overflow from operand
  // and result signs.
  function automatic logic [19:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic [1:0] m);
    logic [16:0] mask, bb, full;
    logic [15:0] s;
    logic        cin, co, ofl;
    mask = (17'd1 << w) - 17'd1;
    bb   = {1'b0, b} & mask;
    cin  = ci;
    if (m == 2'd1 || m == 2'd2) bb = (~bb) & mask;
    if (m == 2'd2) cin = 1'b1;
    full = ({1'b0, a} & mask) + bb + {16'd0, cin};
    co   = full[w];
    s    = full[15:0] & mask[15:0];
    if (m == 2'd2) ofl = 1'b0;
    else ofl = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ofl, co, (s == 16'd0), s[w-1], s};
  endfunction

  // Drive one request; called at a negedge, returns at the negedge after
  // the accepting posedge with in_valid dropped.
  task automatic send(input int w, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic [1:0] m, input bit track);
    exp_t e;
    bit   done;
    logic rdy;
    done = 1'b0;
    if (w == 16) begin
      bus16.in_valid = 1'b1; bus16.a = a; bus16.b = b; bus16.ci = ci; bus16.mode = mode_e'(m);
    end else begin
      bus8.in_valid = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.ci = ci; bus8.mode = mode_e'(m);
    end
    for (int t = 0; t < 64 && !done; t++) begin
      #1;
      rdy = (w == 16) ? bus16.in_ready : bus8.in_ready;
      if (rdy === 1'b1) begin
        e.res = ref_op(w, a, b, ci, m);
        e.acc = cyc + 1;
        if (track) begin
          if (w == 16) q16.push_back(e);
          else q8.push_back(e);
        end
        done = 1'b1;
      end
      @(negedge clk);
    end
    check("accepted", 32'(done), 1);
    if (w == 16) bus16.in_valid = 1'b0;
    else bus8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q16.size() != 0 || q8.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(q16.size() + q8.size()), 0);
  endtask

  // Scoreboard monitors: sample 2 ns after the negedge so the bench's own
  // out_ready/in_valid updates for the coming edge are visible.
  logic pv16 = 1'b0;
  always @(negedge clk) begin
    #2;
    if (bus16.out_valid === 1'b1) begin
      if (!pv16) begin
        if (q16.size() == 0) check("spurious16", bus16.out_valid, 0);
        else check("lat16", 32'(cyc - q16[0].acc), 2);
      end
      if (q16.size() != 0) begin
        check(bus16.out_ready ? "res16" : "hold16",
              {12'd0, bus16.ofl, bus16.co, bus16.z, bus16.n, bus16.s}, {12'd0, q16[0].res});
        if (bus16.out_ready !== 1'b1) check("inrdy_hold16", bus16.in_ready, 0);
        else void'(q16.pop_front());
      end
    end
    pv16 <= (bus16.out_valid === 1'b1);
  end

  logic pv8 = 1'b0;
  always @(negedge clk) begin
    #2;
    if (bus8.out_valid === 1'b1) begin
      if (!pv8) begin
        if (q8.size() == 0) check("spurious8", bus8.out_valid, 0);
        else check("lat8", 32'(cyc - q8[0].acc), 1);
      end
      if (q8.size() != 0) begin
        check("res8", {12'd0, bus8.ofl, bus8.co, bus8.z, bus8.n, 8'd0, bus8.s}, {12'd0, q8[0].res});
        if (bus8.out_ready === 1'b1) void'(q8.pop_front());
      end
    end
    pv8 <= (bus8.out_valid === 1'b1);
  end

  logic [7:0] corners [7];

  initial begin
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0;
    bus16.mode = ADD; bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
    bus8.mode = ADD; bus8.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst16", {10'd0, bus16.in_ready, bus16.out_valid, bus16.ofl, bus16.co,
                    bus16.z, bus16.n, bus16.s}, 0);
    check("rst8", {18'd0, bus8.in_ready, bus8.out_valid, bus8.ofl, bus8.co,
                   bus8.z, bus8.n, bus8.s}, 0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst16", bus16.in_ready, 1);
    check("rdy_after_rst8", bus8.in_ready, 1);
    @(negedge clk);

    // Directed 16-bit operations
    send(16, 16'h00FF, 16'h0001, 1'b0, 2'd0, 1'b1);
    send(16, 16'h8000, 16'h0001, 1'b1, 2'd1, 1'b1);
    send(16, 16'h1234, 16'h1235, 1'b0, 2'd2, 1'b1);
    send(16, 16'hFFFF, 16'h0001, 1'b0, 2'd0, 1'b1);
    send(16, 16'h7FFF, 16'h0001, 1'b0, 2'd3, 1'b1);
    send(16, 16'h0005, 16'h0005, 1'b1, 2'd2, 1'b1);
    drain();

    // Backpressure, then release with a simultaneous new request
    bus16.out_ready = 1'b0;
    send(16, 16'h1234, 16'h4321, 1'b0, 2'd0, 1'b1);
    for (int t = 0; t < 10 && bus16.out_valid !== 1'b1; t++) @(negedge clk);
    check("bp_valid16", bus16.out_valid, 1);
    repeat (2) @(negedge clk);
    bus16.out_ready = 1'b1;
    send(16, 16'h7FFF, 16'h8000, 1'b1, 2'd1, 1'b1);
    drain();

    // Reset on the first CALC cycle aborts the op
    send(16, 16'h1111, 16'h2222, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rdy_in_rst16", bus16.in_ready, 0);
    @(negedge clk);
    #1;
    check("abort_outs16", {11'd0, bus16.out_valid, bus16.ofl, bus16.co, bus16.z,
                           bus16.n, bus16.s}, 0);
    rst_n = 1'b1;
    #1;
    check("rdy_post_abort16", bus16.in_ready, 1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1;
      check("abort_noval16", bus16.out_valid, 0);
    end
    @(negedge clk);

    // Random 16-bit operations
    for (int i = 0; i < 60; i++)
      send(16, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 1'b1);
    drain();

    // 8-bit instance: corner operands for every mode and carry-in
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 7; i++)
          for (int j = 0; j < 7; j++)
            send(8, {8'd0, corners[i]}, {8'd0, corners[j]}, 1'(c), 2'(m), 1'b1);
    for (int i = 0; i < 300; i++)
      send(8, {8'd0, 8'($urandom)}, {8'd0, 8'($urandom)}, 1'($urandom), 2'($urandom), 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
